// File: rtl/clk_period_meter_if.sv
// Signal bundle between the period meter and whatever drives/observes it.
interface clk_period_meter_if #(
  parameter int CntWidth = 26
);
  logic                SigIn;
  logic                Clr;
  logic [CntWidth-1:0] Period;
  logic [CntWidth-1:0] HighTime;
  logic                Valid;
  logic                Locked;
  logic                Timeout;

  modport master (
    output SigIn, Clr,
    input  Period, HighTime, Valid, Locked, Timeout
  );

  modport slave (
    input  SigIn, Clr,
    output Period, HighTime, Valid, Locked, Timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow square wave in Clk cycles, tracks lock against an
// expected period and raises a sticky timeout when rising edges stop arriving.
module clk_period_meter #(
  parameter int CntWidth   = 26,
  parameter int ExpPeriod  = 100002,
  parameter int Tol        = 4,
  parameter int LockCnt    = 2,
  parameter int TimeoutVal = 200000
) (
  input  logic              Clk,
  input  logic              Rst,
  clk_period_meter_if.slave bus
);
  localparam int                  RunWidth    = (LockCnt < 1) ? 1 : $clog2(LockCnt + 1);
  localparam logic [CntWidth-1:0] LoBound     = CntWidth'(ExpPeriod - Tol);
  localparam logic [CntWidth-1:0] HiBound     = CntWidth'(ExpPeriod + Tol);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutVal - 1);
  localparam logic [RunWidth-1:0] RunMax      = RunWidth'(LockCnt);

  typedef enum logic [0:0] {IDLE = 1'b0, MEAS = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, rise_q, rise_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CntWidth-1:0] period_q, period_d, high_time_q, high_time_d;
  logic                valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
  logic [RunWidth-1:0] run_q, run_d;
  logic [CntWidth-1:0] cnt_inc_s;
  logic                in_tol_s;
  logic [RunWidth-1:0] run_inc_s;

  // Synchronizer and registered rising-edge detector; prev_q is SigIn delayed to line up with Rise.
  always_comb begin
    sync1_d = bus.SigIn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  // Measurement FSM, tolerance check and lock run counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cnt_d    = hi_cnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    run_d       = run_q;
    cnt_inc_s   = cnt_q + CntWidth'(1);
    in_tol_s    = (cnt_inc_s >= LoBound) && (cnt_inc_s <= HiBound);
    run_inc_s   = (run_q >= RunMax) ? RunMax : run_q + RunWidth'(1);

    if (bus.Clr) begin
      state_d     = IDLE;
      cnt_d       = '0;
      hi_cnt_d    = '0;
      period_d    = '0;
      high_time_d = '0;
      locked_d    = 1'b0;
      timeout_d   = 1'b0;
      run_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d    = '0;
          hi_cnt_d = '0;
          if (rise_q) begin
            state_d = MEAS;
          end else begin
            state_d = IDLE;
          end
        end
        MEAS: begin
          if (rise_q) begin
            // The Rise cycle itself is high, hence the +1 on both counts.
            period_d    = cnt_inc_s;
            high_time_d = hi_cnt_q + CntWidth'(1);
            valid_d     = 1'b1;
            cnt_d       = '0;
            hi_cnt_d    = '0;
            timeout_d   = 1'b0;
            if (in_tol_s) begin
              run_d    = run_inc_s;
              locked_d = (run_inc_s == RunMax);
            end else begin
              run_d    = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == TimeoutLast) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hi_cnt_d  = '0;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            run_d     = '0;
          end else begin
            cnt_d    = cnt_inc_s;
            hi_cnt_d = hi_cnt_q + CntWidth'(prev_q);
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          hi_cnt_d = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      rise_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_cnt_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      run_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      rise_q      <= rise_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      run_q       <= run_d;
    end
  end

  assign bus.Period   = period_q;
  assign bus.HighTime = high_time_q;
  assign bus.Valid    = valid_q;
  assign bus.Locked   = locked_q;
  assign bus.Timeout  = timeout_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter with a sample-history reference model and a scoreboard.
module tb_clk_period_meter;
  localparam int CW  = 12;
  localparam int EXP = 102;
  localparam int TOL = 4;
  localparam int LC  = 2;
  localparam int TO  = 200;
  localparam int HN  = 32768;

  typedef struct {
    int due;
    int per;
    int hi;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;

  clk_period_meter_if #(.CntWidth(CW)) bus_if ();

  clk_period_meter #(
    .CntWidth(CW), .ExpPeriod(EXP), .Tol(TOL), .LockCnt(LC), .TimeoutVal(TO)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus_if.slave)
  );

  always #5 Clk = ~Clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   hist [0:HN-1];
  exp_t exp_q [$];
  exp_t mon_e;
  bit   armed = 1'b0;
  int   run = 0;
  int   last_rise = 0;
  bit   exp_locked = 1'b0;
  bit   exp_timeout = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: a rise is seen 3 edges after SigIn is first sampled high; period/high time come
  // straight from the recorded sample history between two rises.
  task automatic model_edge(input int n, input bit c);
    bit rise;
    int per;
    int hi;
    rise = (n >= 4) && hist[n-3] && !hist[n-4];
    if (c) begin
      armed = 1'b0; run = 0; exp_locked = 1'b0; exp_timeout = 1'b0;
    end else if (rise) begin
      if (armed) begin
        per = n - last_rise;
        hi  = 0;
        for (int k = last_rise - 3; k <= n - 4; k++) hi += int'(hist[k]);
        if (per >= EXP - TOL && per <= EXP + TOL) begin
          if (run < LC) run++;
        end else begin
          run = 0;
        end
        exp_locked  = (run >= LC);
        exp_timeout = 1'b0;
        exp_q.push_back('{due: n, per: per, hi: hi});
      end
      armed = 1'b1;
      last_rise = n;
    end else if (armed && (n - last_rise == TO)) begin
      armed = 1'b0; run = 0; exp_locked = 1'b0; exp_timeout = 1'b1;
    end
  endtask

  task automatic step(input bit s, input bit c);
    bus_if.SigIn = s;
    bus_if.Clr   = c;
    @(posedge Clk);
    cyc++;
    if (cyc < HN) hist[cyc] = s;
    model_edge(cyc, c);
    #2;
  endtask

  task automatic wave_clr(input int h, input int l, input int clr_at);
    for (int i = 0; i < h + l; i++) step(i < h, i == clr_at);
  endtask

  task automatic wave(input int h, input int l);
    wave_clr(h, l, -1);
  endtask

  task automatic do_reset();
    bus_if.SigIn = 1'b0;
    bus_if.Clr   = 1'b0;
    Rst = 1'b0;
    armed = 1'b0; run = 0; exp_locked = 1'b0; exp_timeout = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_period", int'(bus_if.Period), 0);
    chk("rst_hightime", int'(bus_if.HighTime), 0);
    chk("rst_valid", int'(bus_if.Valid), 0);
    chk("rst_locked", int'(bus_if.Locked), 0);
    chk("rst_timeout", int'(bus_if.Timeout), 0);
    repeat (3) begin
      @(posedge Clk);
      cyc++;
      if (cyc < HN) hist[cyc] = 1'b0;
    end
    #2;
    Rst = 1'b1;
  endtask

  // Scoreboard monitor: pops an expectation on every Valid, checks levels every cycle.
  always @(negedge Clk) begin
    if (bus_if.Valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", int'(bus_if.Valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("valid_cycle", cyc, mon_e.due);
        chk("period", int'(bus_if.Period), mon_e.per);
        chk("hightime", int'(bus_if.HighTime), mon_e.hi);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      chk("missing_valid", int'(bus_if.Valid), 1);
      void'(exp_q.pop_front());
    end
    chk("locked", int'(bus_if.Locked), int'(exp_locked));
    chk("timeout", int'(bus_if.Timeout), int'(exp_timeout));
  end

  initial begin
    int r;
    int per;
    int h;
    Rst = 1'b1;
    bus_if.SigIn = 1'b0;
    bus_if.Clr   = 1'b0;
    #1;
    do_reset();
    wave(0, 6);
    // Nominal wave, then reset in the low half and relock.
    wave(51, 51); wave(51, 51); wave(51, 51);
    wave(51, 20);
    do_reset();
    wave(0, 10);
    wave(51, 51); wave(51, 51); wave(51, 51);
    // One slow period breaks lock, two good ones restore it.
    wave(55, 55); wave(51, 51); wave(51, 51);
    // Tolerance edges: 106 in, 106 in, 97 out, 98 in.
    wave(53, 53); wave(53, 53); wave(48, 49); wave(49, 49); wave(51, 51); wave(51, 51);
    // Input stops: timeout 200 cycles after last rise, then recovery.
    wave(51, 260); wave(51, 51); wave(51, 51); wave(51, 51);
    // Clr coincident with a rise discards it.
    wave_clr(51, 51, 3); wave(51, 51); wave(51, 51); wave(51, 51);
    // 25% duty.
    wave(25, 77); wave(25, 77); wave(25, 77);
    // Minimum period.
    wave(1, 1); wave(1, 1); wave(1, 1); wave(51, 51);
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50) per = EXP - 7 + int'($urandom_range(0, 14));
      else per = int'($urandom_range(2, 150));
      h = int'($urandom_range(1, per - 1));
      if (r >= 95) wave(h, TO + 20);
      else if (r >= 88) wave_clr(h, per - h, int'($urandom_range(0, per - 1)));
      else wave(h, per - h);
    end
    wave(51, 51); wave(51, 51); wave(0, 10);
    chk("drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
